// File: rtl/rv32i_core_top.sv
// Single-cycle RV32I integer core (register-only subset, no data-memory port).
// Latency: one instruction commits per rising edge of clk (register write + PC update).
// Backpressure: none; the instruction ROM is combinational and the core never stalls.
// Ports: clk, rst (async active-low), inst_i (instruction at inst_addr_o),
//        inst_addr_o (byte address of current instruction, equals PC).

module rv32i_regfile (
    input  logic        clk,
    input  logic        rst,
    input  logic [4:0]  rs1_addr,
    input  logic [4:0]  rs2_addr,
    output logic [31:0] rs1_data,
    output logic [31:0] rs2_data,
    input  logic        wr_en,
    input  logic [4:0]  wr_addr,
    input  logic [31:0] wr_data
);
    logic [31:0] regs [0:31];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < 32; i++) begin
                regs[i] <= 32'd0;
            end
        end else if (wr_en && (wr_addr != 5'd0)) begin
            regs[wr_addr] <= wr_data;
        end
    end

    // Reads happen before the clock edge, so rd==rs1 sees the old value.
    assign rs1_data = (rs1_addr == 5'd0) ? 32'd0 : regs[rs1_addr];
    assign rs2_data = (rs2_addr == 5'd0) ? 32'd0 : regs[rs2_addr];
endmodule

module rv32i_core_top #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] inst_i,
    output logic [31:0] inst_addr_o
);
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_REG    = 7'b0110011;

    logic [31:0] pc;
    logic [31:0] pc_next;
    logic [31:0] pc_plus4;

    logic [6:0]  opcode;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [2:0]  funct3;
    logic        alt;

    logic [31:0] imm_i;
    logic [31:0] imm_b;
    logic [31:0] imm_u;
    logic [31:0] imm_j;

    logic [31:0] rs1_data;
    logic [31:0] rs2_data;
    logic [31:0] alu_b;
    logic [4:0]  shamt;
    logic [31:0] alu_res;
    logic        br_taken;

    logic        wr_en;
    logic [31:0] wr_data;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pc <= RESET_PC;
        end else begin
            pc <= pc_next;
        end
    end

    assign inst_addr_o = pc;
    assign pc_plus4    = pc + 32'd4;

    assign opcode = inst_i[6:0];
    assign rd     = inst_i[11:7];
    assign funct3 = inst_i[14:12];
    assign rs1    = inst_i[19:15];
    assign rs2    = inst_i[24:20];
    assign alt    = inst_i[30];

    assign imm_i = {{20{inst_i[31]}}, inst_i[31:20]};
    assign imm_b = {{19{inst_i[31]}}, inst_i[31], inst_i[7], inst_i[30:25], inst_i[11:8], 1'b0};
    assign imm_u = {inst_i[31:12], 12'd0};
    assign imm_j = {{11{inst_i[31]}}, inst_i[31], inst_i[19:12], inst_i[20], inst_i[30:21], 1'b0};

    rv32i_regfile u_regs (
        .clk      (clk),
        .rst      (rst),
        .rs1_addr (rs1),
        .rs2_addr (rs2),
        .rs1_data (rs1_data),
        .rs2_data (rs2_data),
        .wr_en    (wr_en),
        .wr_addr  (rd),
        .wr_data  (wr_data)
    );

    // Register-register and register-immediate ops share one ALU; for the
    // immediate form imm_i[4:0] is exactly inst[24:20], the shift amount.
    assign alu_b = (opcode == OP_REG) ? rs2_data : imm_i;
    assign shamt = alu_b[4:0];

    always_comb begin
        alu_res = 32'd0;
        case (funct3)
            3'd0: alu_res = (opcode == OP_REG && alt) ? (rs1_data - alu_b) : (rs1_data + alu_b);
            3'd1: alu_res = rs1_data << shamt;
            3'd2: alu_res = {31'd0, $signed(rs1_data) < $signed(alu_b)};
            3'd3: alu_res = {31'd0, rs1_data < alu_b};
            3'd4: alu_res = rs1_data ^ alu_b;
            3'd5: alu_res = alt ? 32'($signed(rs1_data) >>> shamt) : (rs1_data >> shamt);
            3'd6: alu_res = rs1_data | alu_b;
            3'd7: alu_res = rs1_data & alu_b;
            default: alu_res = 32'd0;
        endcase
    end

    // funct3 010/011 are not branches; they fall through like a NOP.
    always_comb begin
        br_taken = 1'b0;
        case (funct3)
            3'd0: br_taken = (rs1_data == rs2_data);
            3'd1: br_taken = (rs1_data != rs2_data);
            3'd4: br_taken = ($signed(rs1_data) <  $signed(rs2_data));
            3'd5: br_taken = ($signed(rs1_data) >= $signed(rs2_data));
            3'd6: br_taken = (rs1_data <  rs2_data);
            3'd7: br_taken = (rs1_data >= rs2_data);
            default: br_taken = 1'b0;
        endcase
    end

    // Anything not listed (load, store, fence, system, unknown) is a NOP.
    always_comb begin
        wr_en   = 1'b0;
        wr_data = 32'd0;
        pc_next = pc_plus4;
        case (opcode)
            OP_LUI: begin
                wr_en   = 1'b1;
                wr_data = imm_u;
            end
            OP_AUIPC: begin
                wr_en   = 1'b1;
                wr_data = pc + imm_u;
            end
            OP_JAL: begin
                wr_en   = 1'b1;
                wr_data = pc_plus4;
                pc_next = pc + imm_j;
            end
            OP_JALR: begin
                wr_en   = 1'b1;
                wr_data = pc_plus4;
                pc_next = (rs1_data + imm_i) & ~32'd1;
            end
            OP_BRANCH: begin
                if (br_taken) begin
                    pc_next = pc + imm_b;
                end
            end
            OP_IMM, OP_REG: begin
                wr_en   = 1'b1;
                wr_data = alu_res;
            end
            default: begin
                wr_en   = 1'b0;
            end
        endcase
    end
endmodule

// File: tb/tb_rv32i_core_top.sv
// Bench for rv32i_core_top: directed programs plus random programs from a
// combinational ROM, checked against an instruction-level model.
// Ports exercised: clk, rst, inst_i, inst_addr_o; registers read via dut.u_regs.regs.

module tb_rv32i_core_top;
    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] inst;
    logic [31:0] inst_addr;

    logic [31:0] rom [0:4095];
    assign inst = rom[inst_addr[13:2]];

    always #5 clk = ~clk;

    rv32i_core_top dut (
        .clk         (clk),
        .rst         (rst),
        .inst_i      (inst),
        .inst_addr_o (inst_addr)
    );

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %08h expected %08h at %0t", tag, got, exp, $time);
        end
    endtask

    // ---------------- instruction encoders ----------------
    function automatic logic [31:0] enc_i(input logic [31:0] imm, input logic [4:0] rs1,
                                          input logic [2:0] f3, input logic [4:0] rd,
                                          input logic [6:0] op);
        return {imm[11:0], rs1, f3, rd, op};
    endfunction

    function automatic logic [31:0] enc_r(input logic [6:0] f7, input logic [4:0] rs2,
                                          input logic [4:0] rs1, input logic [2:0] f3,
                                          input logic [4:0] rd);
        return {f7, rs2, rs1, f3, rd, 7'h33};
    endfunction

    function automatic logic [31:0] enc_b(input logic [31:0] imm, input logic [4:0] rs2,
                                          input logic [4:0] rs1, input logic [2:0] f3);
        return {imm[12], imm[10:5], rs2, rs1, f3, imm[4:1], imm[11], 7'h63};
    endfunction

    function automatic logic [31:0] enc_j(input logic [31:0] imm, input logic [4:0] rd);
        return {imm[20], imm[10:1], imm[11], imm[19:12], rd, 7'h6F};
    endfunction

    function automatic logic [31:0] enc_u(input logic [19:0] imm, input logic [4:0] rd,
                                          input logic [6:0] op);
        return {imm, rd, op};
    endfunction

    // ---------------- reference model ----------------
    logic [31:0] mregs [32];
    logic [31:0] mpc;

    function automatic logic [31:0] sext(input logic [31:0] v, input int bits);
        return 32'($signed(v << (32 - bits)) >>> (32 - bits));
    endfunction

    function automatic logic [31:0] m_alu(input logic [2:0] f3, input bit is_sub, input bit is_sra,
                                          input logic [31:0] a, input logic [31:0] b);
        case (f3)
            3'd0: return is_sub ? a - b : a + b;
            3'd1: return a << b[4:0];
            3'd2: return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            3'd3: return (a < b) ? 32'd1 : 32'd0;
            3'd4: return a ^ b;
            3'd5: return is_sra ? 32'($signed(a) >>> b[4:0]) : a >> b[4:0];
            3'd6: return a | b;
            default: return a & b;
        endcase
    endfunction

    // Executes the instruction at mpc; returns the rd field for spot checks.
    task automatic model_step(output logic [4:0] rd);
        logic [31:0] w, a, b, val, nxt, iimm, bimm, jimm;
        bit          wb, take;
        w    = rom[mpc[13:2]];
        rd   = w[11:7];
        a    = mregs[w[19:15]];
        b    = mregs[w[24:20]];
        iimm = sext({20'd0, w[31:20]}, 12);
        bimm = sext({19'd0, w[31], w[7], w[30:25], w[11:8], 1'b0}, 13);
        jimm = sext({11'd0, w[31], w[19:12], w[20], w[30:21], 1'b0}, 21);
        nxt  = mpc + 4;
        wb   = 0;
        val  = 0;
        take = 0;
        case (w[6:0])
            7'h37: begin wb = 1; val = {w[31:12], 12'd0}; end
            7'h17: begin wb = 1; val = mpc + {w[31:12], 12'd0}; end
            7'h6F: begin wb = 1; val = mpc + 4; nxt = mpc + jimm; end
            7'h67: begin wb = 1; val = mpc + 4; nxt = (a + iimm) & 32'hFFFF_FFFE; end
            7'h63: begin
                case (w[14:12])
                    3'd0: take = (a == b);
                    3'd1: take = (a != b);
                    3'd4: take = ($signed(a) <  $signed(b));
                    3'd5: take = ($signed(a) >= $signed(b));
                    3'd6: take = (a <  b);
                    3'd7: take = (a >= b);
                    default: take = 0;
                endcase
                if (take) nxt = mpc + bimm;
            end
            7'h13: begin wb = 1; val = m_alu(w[14:12], 0, w[30], a, iimm); end
            7'h33: begin wb = 1; val = m_alu(w[14:12], w[30], w[30], a, b); end
            default: wb = 0;
        endcase
        if (wb && rd != 0) mregs[rd] = val;
        mpc = nxt;
    endtask

    task automatic model_reset();
        for (int i = 0; i < 32; i++) mregs[i] = 32'd0;
        mpc = 32'd0;
    endtask

    // ---------------- random program generator ----------------
    function automatic logic [31:0] gen_inst();
        logic [4:0]  rd, rs1, rs2;
        logic [2:0]  f3;
        logic [31:0] imm;
        logic [31:0] nops [5];
        rd  = 5'($urandom_range(0, 31));
        rs1 = 5'($urandom_range(0, 31));
        rs2 = 5'($urandom_range(0, 31));
        f3  = 3'($urandom_range(0, 7));
        imm = $urandom;
        nops[0] = 32'h0011_2023;
        nops[1] = 32'h0001_2083;
        nops[2] = 32'h0000_0073;
        nops[3] = 32'h0000_000F;
        nops[4] = {imm[31:7], 7'h7F};
        case ($urandom_range(0, 11))
            0: return enc_u(imm[19:0], rd, 7'h37);
            1: return enc_u(imm[19:0], rd, 7'h17);
            2: return enc_j(32'($signed($urandom_range(0, 64)) - 32) << 1, rd);
            3: return enc_i(imm, rs1, 3'd0, rd, 7'h67);
            4: begin
                while (f3 == 3'd2 || f3 == 3'd3) f3 = 3'($urandom_range(0, 7));
                return enc_b(32'($signed($urandom_range(0, 64)) - 32) << 1, rs2, rs1, f3);
            end
            5, 6, 7: begin
                if (f3 == 3'd1) return enc_i({27'd0, imm[4:0]}, rs1, f3, rd, 7'h13);
                if (f3 == 3'd5) return enc_i({20'd0, 1'b0, imm[10], 5'd0, imm[4:0]}, rs1, f3, rd, 7'h13);
                return enc_i(imm, rs1, f3, rd, 7'h13);
            end
            8, 9, 10: return enc_r((f3 == 3'd0 || f3 == 3'd5) ? {1'b0, imm[30], 5'd0} : 7'd0,
                                   rs2, rs1, f3, rd);
            default: return nops[$urandom_range(0, 4)];
        endcase
    endfunction

    // ---------------- run helpers ----------------
    task automatic clear_rom();
        for (int i = 0; i < 4096; i++) rom[i] = 32'h0000_0013;
    endtask

    task automatic reset_and_check(input string tag);
        @(negedge clk);
        rst = 1'b0;
        #100;
        chk({tag, "_rst_pc"}, inst_addr, 32'd0);
        for (int i = 0; i < 32; i++) chk({tag, "_rst_reg"}, dut.u_regs.regs[i], 32'd0);
        model_reset();
        @(negedge clk);
        rst = 1'b1;
    endtask

    task automatic run_cycles(input string tag, input int n);
        logic [4:0] rd;
        for (int c = 0; c < n; c++) begin
            @(posedge clk);
            #1;
            model_step(rd);
            chk({tag, "_pc"}, inst_addr, mpc);
            chk({tag, "_rd"}, dut.u_regs.regs[rd], mregs[rd]);
        end
    endtask

    task automatic check_all(input string tag);
        for (int i = 0; i < 32; i++) chk({tag, "_reg"}, dut.u_regs.regs[i], mregs[i]);
    endtask

    initial begin
        rst = 1'b0;
        clear_rom();
        model_reset();

        // Arithmetic sequence
        rom[0] = enc_i(2, 0, 3'd0, 10, 7'h13);
        rom[1] = enc_i(1, 11, 3'd0, 11, 7'h13);
        rom[2] = enc_r(7'h00, 10, 11, 3'd0, 12);
        rom[3] = enc_r(7'h20, 10, 12, 3'd0, 13);
        reset_and_check("arith");
        run_cycles("arith", 4);
        chk("arith_x10", dut.u_regs.regs[10], 32'd2);
        chk("arith_x11", dut.u_regs.regs[11], 32'd1);
        chk("arith_x12", dut.u_regs.regs[12], 32'd3);
        chk("arith_x13", dut.u_regs.regs[13], 32'd1);
        chk("arith_pc", inst_addr, 32'd16);

        // Shifts
        clear_rom();
        rom[0] = enc_u(20'h80000, 1, 7'h37);
        rom[1] = enc_i(1, 1, 3'd5, 2, 7'h13);
        rom[2] = enc_i(32'h401, 1, 3'd5, 3, 7'h13);
        rom[3] = enc_i(31, 1, 3'd5, 5, 7'h13);
        rom[4] = enc_i(1, 1, 3'd1, 4, 7'h13);
        reset_and_check("shift");
        run_cycles("shift", 5);
        chk("srli1", dut.u_regs.regs[2], 32'h4000_0000);
        chk("srai1", dut.u_regs.regs[3], 32'hC000_0000);
        chk("srli31", dut.u_regs.regs[5], 32'h0000_0001);
        chk("slli1", dut.u_regs.regs[4], 32'h0000_0000);

        // Control flow
        clear_rom();
        rom[0] = enc_b(8, 0, 0, 3'd0);
        rom[1] = enc_i(7, 0, 3'd0, 6, 7'h13);
        rom[2] = enc_b(8, 0, 0, 3'd1);
        rom[3] = enc_i(9, 0, 3'd0, 7, 7'h13);
        rom[4] = enc_j(12, 1);
        rom[5] = enc_i(3, 0, 3'd0, 8, 7'h13);
        rom[6] = enc_i(5, 0, 3'd0, 0, 7'h13);
        rom[7] = enc_i(1, 1, 3'd0, 5, 7'h67);
        reset_and_check("ctl");
        run_cycles("ctl", 4);
        chk("jal_pc", inst_addr, 32'h1C);
        chk("jal_link", dut.u_regs.regs[1], 32'h14);
        chk("beq_skip", dut.u_regs.regs[6], 32'd0);
        chk("bne_fall", dut.u_regs.regs[7], 32'd9);
        run_cycles("ctl", 1);
        chk("jalr_pc", inst_addr, 32'h14);
        chk("jalr_link", dut.u_regs.regs[5], 32'h20);
        run_cycles("ctl", 2);
        chk("x0_zero", dut.u_regs.regs[0], 32'd0);
        chk("ctl_x8", dut.u_regs.regs[8], 32'd3);

        // Non-executing opcodes
        clear_rom();
        rom[0] = enc_i(32'h55, 0, 3'd0, 1, 7'h13);
        rom[1] = enc_i(32'h100, 0, 3'd0, 2, 7'h13);
        rom[2] = 32'h0011_2023;
        rom[3] = 32'h0001_2083;
        rom[4] = 32'h0000_0073;
        rom[5] = 32'h0000_000F;
        rom[6] = 32'h0000_00FF;
        reset_and_check("nop");
        run_cycles("nop", 7);
        chk("nop_x1", dut.u_regs.regs[1], 32'h55);
        chk("nop_x2", dut.u_regs.regs[2], 32'h100);
        chk("nop_pc", inst_addr, 32'd28);
        check_all("nop");

        // Random programs, one with an asynchronous reset mid-run
        for (int p = 0; p < 4; p++) begin
            for (int i = 0; i < 4096; i++) rom[i] = gen_inst();
            reset_and_check("rand");
            run_cycles("rand", 300);
            check_all("rand");
            if (p == 1) begin
                #2;
                rst = 1'b0;
                #1;
                chk("async_rst_pc", inst_addr, 32'd0);
                for (int i = 0; i < 32; i++) chk("async_rst_reg", dut.u_regs.regs[i], 32'd0);
                model_reset();
                @(negedge clk);
                rst = 1'b1;
                run_cycles("rerun", 300);
                check_all("rerun");
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
